// File: rtl/servo_pulse_meter.sv
// Servo PWM receiver: measures the high time of pwm_in in microseconds and flags
// out-of-range pulses and loss of signal.
module servo_pulse_meter #(
    parameter int unsigned CLK_DIV    = 12,
    parameter int unsigned MIN_US     = 500,
    parameter int unsigned MAX_US     = 2500,
    parameter int unsigned TIMEOUT_US = 25000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwm_in,
    output logic [11:0] width_us,
    output logic        valid,
    output logic        range_err,
    output logic        lost
);

    localparam int unsigned   PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [11:0]   MIN_W      = 12'(MIN_US);
    localparam logic [11:0]   MAX_W      = 12'(MAX_US);
    localparam logic [11:0]   HI_SAT     = 12'hFFF;
    localparam logic [14:0]   GAP_SAT    = 15'(TIMEOUT_US);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        ARMED = 2'd1,
        HIGH  = 2'd2
    } state_t;

    logic          sync1_q, sync2_q, prev_q;
    logic [1:0]    fill_q;
    logic [PW-1:0] presc_q, presc_d;
    state_t        state_q, state_d;
    logic [11:0]   hi_cnt_q, hi_cnt_d;
    logic [14:0]   gap_q, gap_d;
    logic [11:0]   width_q, width_d;
    logic          valid_q, valid_d;
    logic          range_err_q, range_err_d;
    logic          lost_q, lost_d;
    logic          rise, fall, tick, fill_done;

    assign rise      = sync2_q & ~prev_q;
    assign fall      = ~sync2_q & prev_q;
    assign tick      = (presc_q == PRESC_LAST);
    // The synchronizer holds reset zeros until it has sampled the pin twice.
    assign fill_done = (fill_q == 2'd3);

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            fill_q  <= 2'd0;
            presc_q <= '0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            fill_q  <= fill_done ? fill_q : fill_q + 2'd1;
            presc_q <= presc_d;
        end
    end

    always_comb begin
        presc_d = presc_q + 1'b1;
        if (rise || tick) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SYNC;
            hi_cnt_q    <= 12'd0;
            gap_q       <= 15'd0;
            width_q     <= 12'd0;
            valid_q     <= 1'b0;
            range_err_q <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_cnt_q    <= hi_cnt_d;
            gap_q       <= gap_d;
            width_q     <= width_d;
            valid_q     <= valid_d;
            range_err_q <= range_err_d;
            lost_q      <= lost_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        hi_cnt_d    = hi_cnt_q;
        gap_d       = gap_q;
        width_d     = width_q;
        valid_d     = 1'b0;
        range_err_d = range_err_q;
        lost_d      = lost_q;

        // A rise in the same cycle as the timeout tick wins and suppresses lost.
        if (rise) begin
            gap_d = 15'd0;
        end else if (tick && gap_q != GAP_SAT) begin
            gap_d = gap_q + 15'd1;
            if (gap_q == GAP_SAT - 15'd1) begin
                lost_d = 1'b1;
            end
        end

        case (state_q)
            SYNC: begin
                if (fill_done && !sync2_q) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (rise) begin
                    hi_cnt_d = 12'd0;
                    state_d  = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_d = ARMED;
                    if (hi_cnt_q >= MIN_W && hi_cnt_q <= MAX_W) begin
                        width_d     = hi_cnt_q;
                        valid_d     = 1'b1;
                        range_err_d = 1'b0;
                        lost_d      = 1'b0;
                    end else begin
                        range_err_d = 1'b1;
                    end
                end else if (tick && hi_cnt_q != HI_SAT) begin
                    hi_cnt_d = hi_cnt_q + 12'd1;
                    if (hi_cnt_q == HI_SAT - 12'd1) begin
                        lost_d = 1'b1;
                    end
                end
            end
            default: state_d = SYNC;
        endcase
    end

    assign width_us  = width_q;
    assign valid     = valid_q;
    assign range_err = range_err_q;
    assign lost      = lost_q;

endmodule

// File: tb/tb_servo_pulse_meter.sv
// Bench for servo_pulse_meter; runs with a 2-cycle microsecond and a 6000 us
// timeout so the long loss-of-signal cases stay short.
`timescale 1ns/1ps
module tb_servo_pulse_meter;

    localparam int D = 2;
    localparam int T = 6000;

    logic        clk = 1'b0;
    logic        rst;
    logic        pwm_in;
    logic [11:0] width_us;
    logic        valid;
    logic        range_err;
    logic        lost;

    always #5 clk = ~clk;

    servo_pulse_meter #(
        .CLK_DIV   (D),
        .MIN_US    (500),
        .MAX_US    (2500),
        .TIMEOUT_US(T)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pwm_in   (pwm_in),
        .width_us (width_us),
        .valid    (valid),
        .range_err(range_err),
        .lost     (lost)
    );

    typedef struct {
        int n_valid;
        int width;
        int rerr;
        int lost;
    } exp_t;

    typedef struct {
        int   lo_cyc;
        int   hi_cyc;
        exp_t e;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    int   valid_total = 0;
    exp_t sb_q[$];
    vec_t vecs[9];

    // A strobe held for more than one cycle is counted more than once.
    always @(negedge clk) begin
        if (valid) valid_total <= valid_total + 1;
    end

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input int lo_cyc, input int hi_cyc, input int nv,
                                input int w, input int re, input int ls);
        vec_t v;
        v.lo_cyc    = lo_cyc;
        v.hi_cyc    = hi_cyc;
        v.e.n_valid = nv;
        v.e.width   = w;
        v.e.rerr    = re;
        v.e.lost    = ls;
        return v;
    endfunction

    task automatic compare(input string name, input int v0);
        exp_t e;
        e = sb_q.pop_front();
        check({name, " valid strobes"}, valid_total - v0, e.n_valid);
        check({name, " width_us"}, int'(width_us), e.width);
        check({name, " range_err"}, int'(range_err), e.rerr);
        check({name, " lost"}, int'(lost), e.lost);
    endtask

    task automatic run_pulse(input string name, input int lo_cyc, input int hi_cyc, input exp_t e);
        int v0;
        repeat (lo_cyc) @(negedge clk);
        v0 = valid_total;
        sb_q.push_back(e);
        pwm_in = 1'b1;
        repeat (hi_cyc) @(negedge clk);
        pwm_in = 1'b0;
        repeat (8) @(negedge clk);
        compare(name, v0);
    endtask

    task automatic check_zero(input string name);
        check({name, " width_us"}, int'(width_us), 0);
        check({name, " valid"}, int'(valid), 0);
        check({name, " range_err"}, int'(range_err), 0);
        check({name, " lost"}, int'(lost), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   v0;
        int   wait_cyc;
        exp_t e;

        // Pulses of N us are driven as N*D+1 cycles so the width reads exactly N;
        // exactly N*D cycles reads N-1 because the tick coinciding with the fall is dropped.
        vecs[0] = mk(100 * D, 1500 * D + 1, 1, 1500, 0, 0);
        vecs[1] = mk(20,      500 * D + 1,  1, 500,  0, 0);
        vecs[2] = mk(20,      2500 * D + 1, 1, 2500, 0, 0);
        vecs[3] = mk(20,      499 * D + 1,  0, 2500, 1, 0);
        vecs[4] = mk(20,      2502 * D + 1, 0, 2500, 1, 0);
        vecs[5] = mk(20,      1000 * D + 1, 1, 1000, 0, 0);
        vecs[6] = mk(20,      500 * D,      0, 1000, 1, 0);
        vecs[7] = mk(20,      2501 * D + 1, 0, 1000, 1, 0);
        vecs[8] = mk(20,      2500 * D + 2, 1, 2500, 0, 0);

        rst    = 1'b1;
        pwm_in = 1'b0;
        repeat (4) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_pulse($sformatf("vec%0d", i), vecs[i].lo_cyc, vecs[i].hi_cyc, vecs[i].e);
        end

        // Two pulses separated by only 4 low cycles are both measured.
        repeat (20) @(negedge clk);
        v0 = valid_total;
        pwm_in = 1'b1;
        repeat (700 * D + 1) @(negedge clk);
        pwm_in = 1'b0;
        repeat (4) @(negedge clk);
        pwm_in = 1'b1;
        repeat (800 * D + 1) @(negedge clk);
        pwm_in = 1'b0;
        repeat (8) @(negedge clk);
        check("b2b valid strobes", valid_total - v0, 2);
        check("b2b width_us", int'(width_us), 800);

        // Loss of signal: lost sets within 1 us of T us after the last rise.
        e = '{1, 1234, 0, 0};
        run_pulse("pre-loss", 20, 1234 * D + 1, e);
        wait_cyc = T * D - D - (1234 * D + 1 + 8);
        repeat (wait_cyc) @(negedge clk);
        check("loss early lost", int'(lost), 0);
        repeat (2 * D + 3) @(negedge clk);
        check("loss late lost", int'(lost), 1);
        check("loss width_us", int'(width_us), 1234);
        e = '{1, 1000, 0, 0};
        run_pulse("after-loss", 4, 1000 * D + 1, e);

        // Stuck high: lost once hi_cnt saturates at 4095, range_err on release.
        repeat (20) @(negedge clk);
        v0 = valid_total;
        sb_q.push_back('{0, 1000, 1, 1});
        pwm_in = 1'b1;
        repeat (4000 * D) @(negedge clk);
        check("stuck 4000us lost", int'(lost), 0);
        check("stuck 4000us range_err", int'(range_err), 0);
        repeat (1000 * D) @(negedge clk);
        check("stuck 5000us lost", int'(lost), 1);
        pwm_in = 1'b0;
        repeat (8) @(negedge clk);
        compare("stuck release", v0);

        // Pulse already high at reset release is never measured.
        @(negedge clk);
        rst    = 1'b1;
        pwm_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        v0  = valid_total;
        repeat (700 * D) @(negedge clk);
        pwm_in = 1'b0;
        repeat (10) @(negedge clk);
        check("partial valid strobes", valid_total - v0, 0);
        check_zero("partial");
        e = '{1, 1800, 0, 0};
        run_pulse("after-partial", 100, 1800 * D + 1, e);

        // Reset 600 us into a 2000 us pulse clears everything at once.
        repeat (20) @(negedge clk);
        pwm_in = 1'b1;
        repeat (600 * D) @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("mid-pulse reset");
        repeat (4) @(negedge clk);
        rst = 1'b0;
        v0  = valid_total;
        repeat (1400 * D - 4) @(negedge clk);
        pwm_in = 1'b0;
        repeat (10) @(negedge clk);
        check("post-reset tail valid strobes", valid_total - v0, 0);
        check_zero("post-reset tail");
        e = '{1, 1200, 0, 0};
        run_pulse("after-reset", 50, 1200 * D + 1, e);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/servo_pulse_meter.md
Name: servo_pulse_meter

Overview:
Receive-side counterpart of the servo pulse generators in the servos/PP designs. It measures the high time of an incoming servo PWM signal in microseconds from the 12 MHz system clock. Each in-range measurement is published with a one-cycle valid strobe. The block also flags out-of-range pulses and loss of signal. It sits between an input pin and position-decoding or loopback-checking logic.

Parameters:
CLK_DIV, 12, system clock cycles per 1 us tick (12 MHz clock).
MIN_US, 500, shortest accepted pulse width in us.
MAX_US, 2500, longest accepted pulse width in us.
TIMEOUT_US, 25000, us without a rising edge before the signal is declared lost.

Ports:
clk  in  1  system clock, 12 MHz.
rst  in  1  asynchronous, active-high reset.
pwm_in  in  1  servo PWM input, asynchronous to clk.
width_us  out  12  last accepted pulse width in us.
valid  out  1  one-cycle strobe when width_us is updated.
range_err  out  1  last completed pulse was outside [MIN_US, MAX_US].
lost  out  1  no rising edge for TIMEOUT_US, or input stuck high.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: width_us=0, valid=0, range_err=0, lost=0, state=SYNC, all counters 0, synchronizer flops 0.
- Input conditioning:
  - 2-FF synchronizer plus a previous-value flop.
  - rise = s & ~p; fall = ~s & p.
  - Edge detection lags the pin by 3 clk cycles.
- Tick prescaler:
  - Counts 0..CLK_DIV-1; tick=1 when count==CLK_DIV-1.
  - Prescaler restarts at 0 on rise, so each measurement is aligned to the edge.
  - Width quantization is 0/-1 us.
- FSM:
  - SYNC: waits for synced input low, then goes to ARMED. A pulse already in progress at reset is never measured.
  - ARMED: on rise, clear hi_cnt, go to HIGH.
  - HIGH:
    - hi_cnt += 1 on each tick; saturates at 4095.
    - On fall, evaluate hi_cnt and return to ARMED.
- Evaluation on fall (registered, outputs update 1 cycle after the fall detect):
  - MIN_US <= hi_cnt <= MAX_US (bounds inclusive): width_us<=hi_cnt, valid=1 for exactly one cycle, range_err<=0, lost<=0.
  - Otherwise: width_us holds its value, valid stays 0, range_err<=1. range_err is sticky until the next accepted pulse.
- Loss detection:
  - gap_cnt (15 bits) is cleared on rise and by reset, and increments on tick in every state.
  - gap_cnt saturates at TIMEOUT_US. On reaching it, lost<=1.
  - Input stuck high (hi_cnt reaches 4095) also sets lost=1.
  - lost clears only on an accepted pulse.
- Simultaneous events:
  - rise in the same cycle as gap_cnt reaching TIMEOUT_US: the rise wins, gap_cnt clears and lost does not set.
  - fall together with tick: the tick is not counted.
- Reset mid-pulse: all state is discarded immediately; the next measurement starts only after a full low-to-high transition.
- Consecutive pulses: any low time of 4 or more clk cycles between pulses is handled; no minimum period is enforced.

Test Plan:
- After reset, pwm_in low 100 us, then a 1500 us high pulse -> valid exactly once, width_us in {1499,1500}, range_err=0, lost=0.
- Pulses of 500 us and 2500 us, then 499 us and 2502 us:
  - 500 and 2500 are accepted with valid strobes.
  - The later two give range_err=1, no valid, and width_us stays at the 2500 value.
  - A following 1000 us pulse clears range_err.
- No edges for 25 ms after a good pulse -> lost=1 at 25000 +/-1 us after the last rise. A 1000 us pulse then gives valid and lost=0.
- pwm_in held high 5 ms -> lost=1 once hi_cnt reaches 4095. On release, range_err=1 and no valid.
- pwm_in high at reset release, falling 700 us later, then an 1800 us pulse -> the first partial pulse is ignored (no valid, no range_err) and the second reports about 1800.
- Reset asserted 600 us into a 2000 us pulse -> all outputs 0 immediately. The next full 1200 us pulse is measured correctly.
